// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start, data LSB first, optional parity, stop.
// Define UART_TX_HOLD_BUF_EN to add a one-entry hold buffer for back-to-back frames.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy,
  output logic                  tx_ready
);

  localparam int CW = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH) : 3;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  par_nx;
  logic                  pen, pen_nx;
  logic [1:0]            sel_nx;
  logic                  accept;
  logic                  at_edge;
  logic                  ld_dir;
  logic                  ld_buf;
  logic                  ld;
  logic [DATA_WIDTH-1:0] ld_d;
  logic                  ld_pen;
  logic                  ld_typ;

`ifdef UART_TX_HOLD_BUF_EN
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_pen;
  logic                  buf_typ;
  logic                  buf_full;
  logic                  buf_wr;

  assign tx_ready = !buf_full;
`else
  assign tx_ready = (state == IDLE);
`endif

  assign accept   = DATA_VALID & tx_ready;
  assign at_edge  = (state == IDLE) || (state == STOP);
  assign ld_dir   = accept & at_edge;
  assign ser_data = shreg[0];

`ifdef UART_TX_HOLD_BUF_EN
  assign ld_buf = buf_full & at_edge;
  assign buf_wr = accept & ~at_edge;
`else
  assign ld_buf = 1'b0;
`endif

  assign ld = ld_dir | ld_buf;

  // pick the word source for a frame load: buffered word wins
  always_comb begin
    ld_d   = P_DATA;
    ld_pen = PAR_EN;
    ld_typ = PAR_TYP;
`ifdef UART_TX_HOLD_BUF_EN
    if (buf_full) begin
      ld_d   = buf_data;
      ld_pen = buf_pen;
      ld_typ = buf_typ;
    end
`endif
  end

  // next-state and next datapath values
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    par_nx   = par_bit;
    pen_nx   = pen;
    unique case (state)
      IDLE, STOP: begin
        state_nx = IDLE;
        if (ld) begin
          state_nx = START;
          shreg_nx = ld_d;
          par_nx   = ^ld_d ^ ld_typ;
          pen_nx   = ld_pen;
        end
      end
      START: begin
        state_nx = DATA;
        cnt_nx   = '0;
      end
      DATA: begin
        if (cnt == LAST) begin
          state_nx = pen ? PARITY : STOP;
        end else begin
          shreg_nx = shreg >> 1;
          cnt_nx   = cnt + 1'b1;
        end
      end
      PARITY: state_nx = STOP;
      default: state_nx = IDLE;
    endcase
  end

  // mux select mirrors the state being entered
  always_comb begin
    sel_nx = 2'b11;
    unique case (state_nx)
      START:   sel_nx = 2'b00;
      DATA:    sel_nx = 2'b01;
      PARITY:  sel_nx = 2'b10;
      default: sel_nx = 2'b11;
    endcase
  end

  // state register
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // registered datapath and outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shreg   <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
      pen     <= 1'b0;
      mux_sel <= 2'b11;
      busy    <= 1'b0;
    end else begin
      shreg   <= shreg_nx;
      cnt     <= cnt_nx;
      par_bit <= par_nx;
      pen     <= pen_nx;
      mux_sel <= sel_nx;
      busy    <= (state_nx != IDLE);
    end
  end

`ifdef UART_TX_HOLD_BUF_EN
  // hold buffer: fills while a frame runs, drains at STOP
  always_ff @(posedge CLK) begin
    if (!RST) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      buf_pen  <= 1'b0;
      buf_typ  <= 1'b0;
    end else if (buf_wr) begin
      buf_full <= 1'b1;
      buf_data <= P_DATA;
      buf_pen  <= PAR_EN;
      buf_typ  <= PAR_TYP;
    end else if (ld_buf) begin
      buf_full <= 1'b0;
    end
  end
`endif

endmodule
